host_mem_ctrl: RTL and testbench
================================

# host_mem_ctrl

Host-side memory controller for the tiny processor. It decodes serial frames from the external master on `csi`/`csd`/`mosi`, then writes or reads back one 8-bit word in the instruction or data cache. It also arbitrates cache ownership between the host and the processor core, issuing the start request for a program run. It sits between the uio pins and the cache address/data/enable muxes.

## Interface
Parameters:
- `ADDR_W`, 4, cache address width
- `DATA_W`, 8, cache word width

Ports:
- `clk`  in  1  clock; master shifts `mosi` on this clock
- `rst`  in  1  reset, synchronous, active-high
- `csi_n`  in  1  instruction-cache frame select, active-low
- `csd_n`  in  1  data-cache frame select, active-low
- `mosi`  in  1  serial data from master, sampled every `clk` edge
- `run`  in  1  master request for processor execution
- `proc_done`  in  1  processor idle/finished
- `mem_rdata`  in  DATA_W  combinational read data of the selected cache at `mem_addr`
- `miso`  out  1  serial read-back data, MSB first
- `mem_sel`  out  1  0 = icache, 1 = dcache
- `mem_addr`  out  ADDR_W  host cache address
- `mem_wdata`  out  DATA_W  host write data
- `mem_wen`  out  1  one-cycle write strobe
- `host_grant`  out  1  1 = caches driven by host ports, 0 = processor owns caches
- `proc_start`  out  1  one-cycle start pulse to processor
- `frame_err`  out  1  sticky error flag
- `busy`  out  1  state != IDLE

## Operation
- Frame format, MSB first, one bit per cycle while select is low: `cmd` (0 = write, 1 = read), `a3..a0`, then for write `d7..d0`. A write frame is 13 bits; a read frame is 5 bits followed by a read-back.
- States:
  - **IDLE**
    - Exactly one select low: go to ADDR. The bit on that cycle is `cmd`, `mem_sel` latches `~csd_n`, `frame_err` clears.
    - Both selects low: set `frame_err`, go to WAIT_CS.
    - Both selects high and `run`=1: pulse `proc_start`, go to RUN.
    - Frame start has priority over `run` in the same cycle.
  - **ADDR**: shift in 4 address bits. After `a0`, go to WDATA if `cmd`=0, else LATCH.
  - **WDATA**: shift in 8 data bits. After `d0`, go to COMMIT.
  - **COMMIT**: `mem_wen`=1 for exactly one cycle, with `mem_addr`/`mem_wdata`/`mem_sel` stable. Then go to IDLE if both selects are high, else WAIT_CS.
  - **LATCH**: load the 8-bit shift register from `mem_rdata`. `miso`=0. Go to RDATA.
  - **RDATA**: 8 cycles, `miso` = shift register MSB, shift left each cycle. Then go to IDLE or WAIT_CS, same rule as COMMIT.
  - **WAIT_CS**: ignore `mosi` until both selects are high, then go to IDLE.
  - **RUN**: `host_grant`=0; select and `mosi` activity is ignored with no error. Exit when `proc_done`=1 and `run`=0: go to IDLE if both selects are high, else WAIT_CS.
- Abort rules:
  - In ADDR, WDATA, LATCH or RDATA, the active select rising, or the other select falling, sets `frame_err` and returns to IDLE (or WAIT_CS if any select is still low). No write occurs.
  - COMMIT ignores select changes.
- `frame_err` is set only as above and cleared only by a valid frame start or `rst`.
- Bit counter is 4 bits and saturates. Extra bits beyond the frame length are absorbed in WAIT_CS.

## Timing
- Reset values: state IDLE; `miso`, `mem_wen`, `proc_start`, `frame_err`, `busy` = 0; `mem_addr`, `mem_wdata`, `mem_sel` = 0; `host_grant` = 1.
- Cycle 0 is defined as the first cycle with a select low.
- Write frame:
  - Data bits arrive on cycles 5..12.
  - `mem_wen` is high on cycle 13.
  - The write lands in the cache at the end of cycle 13.
- Read frame:
  - `mem_addr` is valid from cycle 5.
  - LATCH is cycle 5.
  - `miso` carries `d7..d0` on cycles 6..13.
  - The select must stay low through cycle 13.
- `proc_start` is high for exactly one cycle, on the cycle after RUN is entered from IDLE. `host_grant` drops on that same cycle.
- `host_grant` returns to 1 on the cycle after RUN is exited.
- `rst` mid-frame: next cycle is IDLE, with no `mem_wen` and no partial data retained.

## Test plan
- **Write:** `csi_n` low 13 cycles with bits `0,0101,10100111` -> `mem_wen`=1 on cycle 13 only, with `mem_sel`=0, `mem_addr`=5, `mem_wdata`=0xA7; `frame_err`=0.
- **Read:** `csd_n` low, bits `1,0011`, `mem_rdata`=0x3C -> `mem_sel`=1, `mem_addr`=3; `miso`=0,0,1,1,1,1,0,0 on cycles 6..13; no `mem_wen`.
- **Abort:** `csi_n` released after 9 bits of a write frame -> no `mem_wen`, `frame_err`=1; the next valid frame start clears it.
- **Select collision:** both selects low together -> `frame_err`=1, state WAIT_CS, no `mem_wen` until both selects are high and a fresh frame is sent.
- **Run:**
  - `run`=1 from IDLE -> `proc_start` single pulse and `host_grant`=0.
  - A write frame sent during RUN causes no `mem_wen`.
  - `proc_done`=1 with `run`=0 -> `host_grant`=1 on the next cycle.
- **Reset mid-write:** assert `rst` at cycle 8 of a write frame -> all outputs at reset values and no `mem_wen`; a subsequent full frame writes correctly.

Source files
------------

// File: rtl/host_mem_ctrl_if.sv
// Host-side pin and cache-port bundle for host_mem_ctrl.
// master = external host/cache side, slave = controller.
interface host_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic              csi_n;
  logic              csd_n;
  logic              mosi;
  logic              run;
  logic              proc_done;
  logic [DATA_W-1:0] mem_rdata;
  logic              miso;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wen;
  logic              host_grant;
  logic              proc_start;
  logic              frame_err;
  logic              busy;

  modport master (
    output csi_n, csd_n, mosi, run, proc_done, mem_rdata,
    input  miso, mem_sel, mem_addr, mem_wdata, mem_wen,
    input  host_grant, proc_start, frame_err, busy
  );

  modport slave (
    input  csi_n, csd_n, mosi, run, proc_done, mem_rdata,
    output miso, mem_sel, mem_addr, mem_wdata, mem_wen,
    output host_grant, proc_start, frame_err, busy
  );
endinterface

// File: rtl/host_mem_ctrl.sv
// Serial-frame host memory controller: decodes write/read frames into one
// cache word access and arbitrates cache ownership with the processor core.
module host_mem_ctrl #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input logic            clk,
  input logic            rst,
  host_mem_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_COMMIT, S_LATCH, S_RDATA, S_WAIT_CS, S_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              cmd_q, cmd_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              miso_q, miso_d;
  logic              err_q, err_d;
  logic              wen_q, wen_d;
  logic              start_q, start_d;
  logic              grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              act_n, oth_n, abort, both_hi;

  // Select of the frame in progress versus the other one
  assign act_n   = sel_q ? bus.csd_n : bus.csi_n;
  assign oth_n   = sel_q ? bus.csi_n : bus.csd_n;
  assign abort   = act_n | ~oth_n;
  assign both_hi = bus.csi_n & bus.csd_n;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cmd_q   <= 1'b0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      sh_q    <= '0;
      miso_q  <= 1'b0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      start_q <= 1'b0;
      grant_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      sh_q    <= sh_d;
      miso_q  <= miso_d;
      err_q   <= err_d;
      wen_q   <= wen_d;
      start_q <= start_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    sh_d    = sh_q;
    miso_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.csi_n ^ bus.csd_n) begin
          state_d = S_ADDR;
          cmd_d   = bus.mosi;
          sel_d   = ~bus.csd_n;
          err_d   = 1'b0;
          cnt_d   = '0;
        end else if (!bus.csi_n && !bus.csd_n) begin
          err_d   = 1'b1;
          state_d = S_WAIT_CS;
        end else if (bus.run) begin
          state_d = S_RUN;
        end
      end
      S_ADDR: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = both_hi ? S_IDLE : S_WAIT_CS;
        end else begin
          addr_d = {addr_q[ADDR_W-2:0], bus.mosi};
          cnt_d  = cnt_inc;
          if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            cnt_d   = '0;
            state_d = cmd_q ? S_LATCH : S_WDATA;
          end
        end
      end
      S_WDATA: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = both_hi ? S_IDLE : S_WAIT_CS;
        end else begin
          sh_d  = {sh_q[DATA_W-2:0], bus.mosi};
          cnt_d = cnt_inc;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d   = '0;
            state_d = S_COMMIT;
          end
        end
      end
      S_COMMIT: state_d = both_hi ? S_IDLE : S_WAIT_CS;
      S_LATCH: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = both_hi ? S_IDLE : S_WAIT_CS;
        end else begin
          // MSB goes straight to miso so d7 appears on the first RDATA cycle
          sh_d    = {bus.mem_rdata[DATA_W-2:0], 1'b0};
          miso_d  = bus.mem_rdata[DATA_W-1];
          cnt_d   = '0;
          state_d = S_RDATA;
        end
      end
      S_RDATA: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = both_hi ? S_IDLE : S_WAIT_CS;
        end else if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = both_hi ? S_IDLE : S_WAIT_CS;
        end else begin
          miso_d = sh_q[DATA_W-1];
          sh_d   = {sh_q[DATA_W-2:0], 1'b0};
          cnt_d  = cnt_inc;
        end
      end
      S_WAIT_CS: if (both_hi) state_d = S_IDLE;
      S_RUN: begin
        if (bus.proc_done && !bus.run) state_d = both_hi ? S_IDLE : S_WAIT_CS;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs registered from the next state so they align with it
  always_comb begin
    wen_d   = (state_d == S_COMMIT);
    start_d = (state_q == S_IDLE) && (state_d == S_RUN);
    grant_d = (state_d != S_RUN);
    busy_d  = (state_d != S_IDLE);
  end

  assign bus.miso       = miso_q;
  assign bus.mem_sel    = sel_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = sh_q;
  assign bus.mem_wen    = wen_q;
  assign bus.host_grant = grant_q;
  assign bus.proc_start = start_q;
  assign bus.frame_err  = err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_host_mem_ctrl.sv
// Directed bench for host_mem_ctrl with a two-bank cache model behind the ports.
module tb_host_mem_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   wen_cnt;
  logic [7:0] imem [16];
  logic [7:0] dmem [16];

  host_mem_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  host_mem_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb bus.mem_rdata = bus.mem_sel ? dmem[bus.mem_addr] : imem[bus.mem_addr];

  // Cache model: write lands at the end of the strobe cycle
  always @(posedge clk) begin
    if (bus.mem_wen) begin
      wen_cnt <= wen_cnt + 1;
      if (bus.mem_sel) dmem[bus.mem_addr] <= bus.mem_wdata;
      else             imem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge; outputs seen now belong to this cycle
  task automatic cyc(input logic ci, input logic cd, input logic m);
    @(negedge clk);
    bus.csi_n = ci;
    bus.csd_n = cd;
    bus.mosi  = m;
  endtask

  task automatic shift_bits(input logic sel, input logic [12:0] bits, input int n);
    for (int i = 0; i < n; i++) cyc(sel, ~sel, bits[12-i]);
  endtask

  task automatic send_write(input logic sel, input logic [3:0] a, input logic [7:0] d);
    int w0;
    w0 = wen_cnt;
    shift_bits(sel, {1'b0, a, d}, 13);
    cyc(1'b1, 1'b1, 1'b0);
    check("wr_wen13", bus.mem_wen, 1'b1);
    check("wr_sel", bus.mem_sel, sel);
    check("wr_addr", bus.mem_addr, a);
    check("wr_data", bus.mem_wdata, d);
    check("wr_err", bus.frame_err, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check("wr_wen14", bus.mem_wen, 1'b0);
    check("wr_busy14", bus.busy, 1'b0);
    check("wr_count", wen_cnt, w0 + 1);
  endtask

  task automatic send_read(input logic sel, input logic [3:0] a, input logic [7:0] exp);
    int w0;
    w0 = wen_cnt;
    shift_bits(sel, {1'b1, a, 8'h00}, 5);
    cyc(sel, ~sel, 1'b0);
    check("rd_sel", bus.mem_sel, sel);
    check("rd_addr", bus.mem_addr, a);
    check("rd_miso5", bus.miso, 1'b0);
    for (int c = 6; c <= 13; c++) begin
      cyc(sel, ~sel, 1'b0);
      check($sformatf("rd_miso%0d", c), bus.miso, exp[13-c]);
    end
    cyc(1'b1, 1'b1, 1'b0);
    check("rd_miso14", bus.miso, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check("rd_busy15", bus.busy, 1'b0);
    check("rd_nowen", wen_cnt, w0);
  endtask

  initial begin
    int w0;
    checks = 0;
    errors = 0;
    wen_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      imem[i] = 8'(i);
      dmem[i] = 8'(8'hF0 + i);
    end
    dmem[3] = 8'h3C;
    rst = 1'b1;
    bus.csi_n = 1'b1;
    bus.csd_n = 1'b1;
    bus.mosi = 1'b0;
    bus.run = 1'b0;
    bus.proc_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_grant", bus.host_grant, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_wen", bus.mem_wen, 1'b0);
    check("rst_err", bus.frame_err, 1'b0);
    rst = 1'b0;
    cyc(1'b1, 1'b1, 1'b0);

    // Write then read back through the cache model
    send_write(1'b0, 4'd5, 8'hA7);
    send_read(1'b1, 4'd3, 8'h3C);
    send_read(1'b0, 4'd5, 8'hA7);

    // Abort after 9 bits of a write frame
    w0 = wen_cnt;
    shift_bits(1'b0, 13'b0_0010_11110000, 9);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check("abort_err", bus.frame_err, 1'b1);
    check("abort_busy", bus.busy, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check("abort_nowen", wen_cnt, w0);
    send_write(1'b0, 4'd2, 8'h11);

    // Select collision
    w0 = wen_cnt;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    check("coll_err", bus.frame_err, 1'b1);
    check("coll_busy1", bus.busy, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    check("coll_busy2", bus.busy, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    check("coll_busy3", bus.busy, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    check("coll_idle", bus.busy, 1'b0);
    check("coll_err_hold", bus.frame_err, 1'b1);
    check("coll_nowen", wen_cnt, w0);
    send_write(1'b1, 4'd7, 8'hC3);
    send_read(1'b1, 4'd7, 8'hC3);

    // Run handoff; frames during RUN are ignored
    cyc(1'b1, 1'b1, 1'b0);
    bus.run = 1'b1;
    check("run_pre_grant", bus.host_grant, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    check("run_start", bus.proc_start, 1'b1);
    check("run_grant", bus.host_grant, 1'b0);
    check("run_busy", bus.busy, 1'b1);
    bus.run = 1'b0;
    cyc(1'b1, 1'b1, 1'b0);
    check("run_start_once", bus.proc_start, 1'b0);
    check("run_grant_hold", bus.host_grant, 1'b0);
    w0 = wen_cnt;
    shift_bits(1'b0, 13'b0_1001_01010101, 13);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check("run_nowen", wen_cnt, w0);
    check("run_noerr", bus.frame_err, 1'b0);
    check("run_grant_frame", bus.host_grant, 1'b0);
    bus.proc_done = 1'b1;
    check("run_exit_cycle", bus.host_grant, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    bus.proc_done = 1'b0;
    check("run_grant_back", bus.host_grant, 1'b1);
    check("run_idle", bus.busy, 1'b0);
    check("run_start_low", bus.proc_start, 1'b0);
    check("run_mem9", imem[9], 8'h09);

    // Reset in cycle 8 of a dcache write frame
    w0 = wen_cnt;
    shift_bits(1'b1, 13'b0_1011_01011110, 8);
    cyc(1'b0, 1'b0, 1'b0);
    bus.csi_n = 1'b1;
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    check("rstm_busy", bus.busy, 1'b0);
    check("rstm_wen", bus.mem_wen, 1'b0);
    check("rstm_addr", bus.mem_addr, 4'd0);
    check("rstm_wdata", bus.mem_wdata, 8'h00);
    check("rstm_sel", bus.mem_sel, 1'b0);
    check("rstm_miso", bus.miso, 1'b0);
    check("rstm_start", bus.proc_start, 1'b0);
    check("rstm_err", bus.frame_err, 1'b0);
    check("rstm_grant", bus.host_grant, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    check("rstm_nowen", wen_cnt, w0);
    check("rstm_mem", dmem[11], 8'hFB);
    send_write(1'b1, 4'd11, 8'h5E);
    send_read(1'b1, 4'd11, 8'h5E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
